pcode_grant_decoder: RTL and testbench

Sequential decoder for the 3-bit priority code produced by the team's 4-input priority encoder. It accepts one code at a time over a valid/ready handshake and drives the matching one-hot grant line for a programmable number of cycles. After each grant it inserts one idle gap cycle. It sits downstream of the encoder in request/grant paths and also counts grants and flags illegal codes.

---
 rtl/pcode_grant_decoder.sv | 96 +++++++++
 tb/tb_pcode_grant_decoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcode_grant_decoder.sv
// Decodes a 3-bit priority code into a one-hot grant held for HOLD_CYCLES, then one idle gap cycle.
// Latency: accept edge N -> grant in cycles N+1..N+HOLD_CYCLES, gap in N+HOLD_CYCLES+1.
// Backpressure: pcode_ready is high only in IDLE; codes offered while busy wait for the next IDLE cycle.
module pcode_grant_decoder #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] pcode,
    input  logic       pcode_valid,
    output logic       pcode_ready,
    input  logic       release_req,
    output logic [4:1] grant,
    output logic       busy,
    output logic [7:0] grant_cnt,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] code_q;
    logic [7:0] hold_q;
    logic       accept;
    logic       code_legal;
    logic       code_illegal;
    logic [4:1] grant_dec;

    assign accept       = pcode_valid && (state_q == ST_IDLE);
    assign code_legal   = (pcode != 3'd0) && (pcode <= 3'd4);
    assign code_illegal = (pcode >= 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && code_legal) state_d = ST_GRANT;
            ST_GRANT: if ((hold_q == 8'd0) || release_req) state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= 3'd0;
            hold_q    <= 8'd0;
            grant_cnt <= 8'd0;
            err       <= 1'b0;
        end else begin
            if (accept && code_legal) begin
                code_q <= pcode;
                hold_q <= HOLD_LOAD;
                if (grant_cnt != 8'hFF) begin
                    grant_cnt <= grant_cnt + 8'd1;
                end
            end else if ((state_q == ST_GRANT) && (hold_q != 8'd0)) begin
                hold_q <= hold_q - 8'd1;
            end
            if (accept && code_illegal) begin
                err <= 1'b1;
            end
        end
    end

    // Decoding the latched code (not pcode) keeps every output off the input-to-output path.
    always_comb begin
        grant_dec = 4'b0000;
        case (code_q)
            3'd1:    grant_dec = 4'b0001;
            3'd2:    grant_dec = 4'b0010;
            3'd3:    grant_dec = 4'b0100;
            3'd4:    grant_dec = 4'b1000;
            default: grant_dec = 4'b0000;
        endcase
    end

    assign grant       = (state_q == ST_GRANT) ? grant_dec : 4'b0000;
    assign busy        = (state_q != ST_IDLE);
    assign pcode_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_pcode_grant_decoder.sv
// Directed bench for pcode_grant_decoder: main instance with HOLD_CYCLES=4, second with HOLD_CYCLES=1.
module tb_pcode_grant_decoder;

    logic       clk;
    logic       rst_n;
    logic [2:0] pcode;
    logic       pcode_valid;
    logic       pcode_ready;
    logic       release_req;
    logic [4:1] grant;
    logic       busy;
    logic [7:0] grant_cnt;
    logic       err;

    logic [2:0] s_pcode;
    logic       s_valid;
    logic       s_ready;
    logic       s_release;
    logic [4:1] s_grant;
    logic       s_busy;
    logic [7:0] s_cnt;
    logic       s_err;

    int vecs;
    int miscompares;

    pcode_grant_decoder #(.HOLD_CYCLES(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcode       (pcode),
        .pcode_valid (pcode_valid),
        .pcode_ready (pcode_ready),
        .release_req (release_req),
        .grant       (grant),
        .busy        (busy),
        .grant_cnt   (grant_cnt),
        .err         (err)
    );

    pcode_grant_decoder #(.HOLD_CYCLES(1)) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcode       (s_pcode),
        .pcode_valid (s_valid),
        .pcode_ready (s_ready),
        .release_req (s_release),
        .grant       (s_grant),
        .busy        (s_busy),
        .grant_cnt   (s_cnt),
        .err         (s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        pcode       = 3'd0;
        pcode_valid = 1'b0;
        release_req = 1'b0;
        s_pcode     = 3'd0;
        s_valid     = 1'b0;
        s_release   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        pcode       = 3'd0;
        pcode_valid = 1'b0;
        release_req = 1'b0;
        s_pcode     = 3'd0;
        s_valid     = 1'b0;
        s_release   = 1'b0;
        #2;
        vecs++;
        if ({grant, busy, pcode_ready, grant_cnt, err} !== {4'b0000, 1'b0, 1'b1, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got grant=%b busy=%b rdy=%b cnt=%0d err=%b, want 0000 0 1 0 0",
                     grant, busy, pcode_ready, grant_cnt, err);
        end
        vecs++;
        if ({s_grant, s_busy, s_ready, s_cnt, s_err} !== {4'b0000, 1'b0, 1'b1, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state_sat: got grant=%b busy=%b rdy=%b cnt=%0d err=%b, want 0000 0 1 0 0",
                     s_grant, s_busy, s_ready, s_cnt, s_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if ({grant, busy, pcode_ready} !== {4'b0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_idle: got grant=%b busy=%b rdy=%b, want 0000 0 1", grant, busy, pcode_ready);
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp_g;
        logic       exp_b;
        logic       exp_r;
        apply_reset();
        pcode       = 3'b011;
        pcode_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) pcode_valid = 1'b0;
            exp_g = (i <= 4) ? 4'b0100 : 4'b0000;
            exp_b = (i <= 5);
            exp_r = (i == 6);
            vecs++;
            if ({grant, busy, pcode_ready} !== {exp_g, exp_b, exp_r}) begin
                miscompares++;
                $display("FAIL basic_cyc%0d: got grant=%b busy=%b rdy=%b, want %b %b %b",
                         i, grant, busy, pcode_ready, exp_g, exp_b, exp_r);
            end
        end
        vecs++;
        if (grant_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL basic_cnt: got %0d, want 1", grant_cnt);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] exp_g;
        int         legal_cnt;
        legal_cnt = 0;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            pcode       = 3'(c);
            pcode_valid = 1'b1;
            @(negedge clk);
            pcode_valid = 1'b0;
            case (c)
                1:       exp_g = 4'b0001;
                2:       exp_g = 4'b0010;
                3:       exp_g = 4'b0100;
                4:       exp_g = 4'b1000;
                default: exp_g = 4'b0000;
            endcase
            if (exp_g != 4'b0000) legal_cnt++;
            vecs++;
            if ({grant, busy, grant_cnt, err} !== {exp_g, (exp_g != 4'b0000), 8'(legal_cnt), (c >= 5)}) begin
                miscompares++;
                $display("FAIL sweep_code%0d: got grant=%b busy=%b cnt=%0d err=%b, want %b %b %0d %b",
                         c, grant, busy, grant_cnt, err, exp_g, (exp_g != 4'b0000), legal_cnt, (c >= 5));
            end
            if (exp_g != 4'b0000) begin
                repeat (5) @(negedge clk);
                vecs++;
                if (pcode_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sweep_ready_code%0d: got %b, want 1", c, pcode_ready);
                end
            end
        end
        vecs++;
        if ({grant_cnt, err} !== {8'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL sweep_final: got cnt=%0d err=%b, want 4 1", grant_cnt, err);
        end
    endtask

    task automatic test_release();
        apply_reset();
        pcode       = 3'd4;
        pcode_valid = 1'b1;
        @(negedge clk);
        pcode_valid = 1'b0;
        vecs++;
        if ({grant, busy} !== {4'b1000, 1'b1}) begin
            miscompares++;
            $display("FAIL release_g1: got grant=%b busy=%b, want 1000 1", grant, busy);
        end
        @(negedge clk);
        release_req = 1'b1;
        vecs++;
        if ({grant, busy} !== {4'b1000, 1'b1}) begin
            miscompares++;
            $display("FAIL release_g2: got grant=%b busy=%b, want 1000 1", grant, busy);
        end
        @(negedge clk);
        release_req = 1'b0;
        vecs++;
        if ({grant, busy, pcode_ready} !== {4'b0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL release_gap: got grant=%b busy=%b rdy=%b, want 0000 1 0", grant, busy, pcode_ready);
        end
        @(negedge clk);
        vecs++;
        if ({grant, busy, pcode_ready} !== {4'b0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL release_idle: got grant=%b busy=%b rdy=%b, want 0000 0 1", grant, busy, pcode_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g;
        int         phase;
        int         idx;
        apply_reset();
        pcode_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            phase = k % 6;
            idx   = k / 6;
            exp_g = (phase >= 1 && phase <= 4) ? ((idx % 2 == 1) ? 4'b0010 : 4'b0001) : 4'b0000;
            vecs++;
            if ({grant, busy, pcode_ready} !== {exp_g, (phase != 0), (phase == 0)}) begin
                miscompares++;
                $display("FAIL b2b_cyc%0d: got grant=%b busy=%b rdy=%b, want %b %b %b",
                         k, grant, busy, pcode_ready, exp_g, (phase != 0), (phase == 0));
            end
            if (phase == 0) pcode = (idx % 2 == 1) ? 3'd2 : 3'd1;
            else            pcode = (phase % 2 == 1) ? 3'd3 : 3'd4;
        end
        pcode_valid = 1'b0;
        vecs++;
        if (grant_cnt !== 8'd4) begin
            miscompares++;
            $display("FAIL b2b_cnt: got %0d, want 4", grant_cnt);
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        pcode       = 3'd7;
        pcode_valid = 1'b1;
        @(negedge clk);
        pcode = 3'd2;
        @(negedge clk);
        pcode_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if ({grant, err, grant_cnt} !== {4'b0010, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL midrst_pre: got grant=%b err=%b cnt=%0d, want 0010 1 1", grant, err, grant_cnt);
        end
        #1 rst_n = 1'b0;
        #1;
        vecs++;
        if ({grant, busy, pcode_ready, grant_cnt, err} !== {4'b0000, 1'b0, 1'b1, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_async: got grant=%b busy=%b rdy=%b cnt=%0d err=%b, want 0000 0 1 0 0",
                     grant, busy, pcode_ready, grant_cnt, err);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        pcode       = 3'd3;
        pcode_valid = 1'b1;
        @(negedge clk);
        pcode_valid = 1'b0;
        vecs++;
        if ({grant, busy, grant_cnt, err} !== {4'b0100, 1'b1, 8'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_after: got grant=%b busy=%b cnt=%0d err=%b, want 0100 1 1 0",
                     grant, busy, grant_cnt, err);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        apply_reset();
        s_pcode = 3'd1;
        s_valid = 1'b1;
        for (int k = 0; k < 768; k++) begin
            if (k > 0) @(negedge clk);
            exp_cnt = (k + 2) / 3;
            if (exp_cnt > 255) exp_cnt = 255;
            vecs++;
            if (s_cnt !== 8'(exp_cnt)) begin
                miscompares++;
                $display("FAIL sat_cnt_cyc%0d: got %0d, want %0d", k, s_cnt, exp_cnt);
            end
            if (k == 1 || k == 2) begin
                vecs++;
                if ({s_grant, s_busy} !== {((k == 1) ? 4'b0001 : 4'b0000), 1'b1}) begin
                    miscompares++;
                    $display("FAIL sat_hold1_cyc%0d: got grant=%b busy=%b", k, s_grant, s_busy);
                end
            end
        end
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({s_cnt, s_err} !== {8'd255, 1'b0}) begin
            miscompares++;
            $display("FAIL sat_final: got cnt=%0d err=%b, want 255 0", s_cnt, s_err);
        end
    endtask

    initial begin
        vecs        = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_sweep();
        test_release();
        test_back_to_back();
        test_reset_mid_grant();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
